// File: rtl/sobel_line_packer_if.sv
// Pixel-side edge stream and byte-wide packet stream of the Sobel line packer.
// The packer connects through "master"; the pixel source and packet sink use "slave".
interface sobel_line_packer_if;
    logic        sobel;
    logic        sobel_valid;
    logic        sobel_hsync;
    logic        sobel_vsync;
    logic [7:0]  pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_sop;
    logic        pkt_eop;
    logic        line_drop;
    logic [15:0] drop_count;

    modport master (
        input  sobel, sobel_valid, sobel_hsync, sobel_vsync, pkt_ready,
        output pkt_data, pkt_valid, pkt_sop, pkt_eop, line_drop, drop_count
    );

    modport slave (
        output sobel, sobel_valid, sobel_hsync, sobel_vsync, pkt_ready,
        input  pkt_data, pkt_valid, pkt_sop, pkt_eop, line_drop, drop_count
    );
endinterface

// File: rtl/sobel_line_packer.sv
// Packs the 1-bit edge stream into bytes, buffers whole lines in two ping-pong banks
// and sends each line as a packet: 2-byte line number header, then IMAGE_WIDTH/8 bytes.
module sobel_line_packer #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720
) (
    input logic clk,
    input logic rst_p,
    sobel_line_packer_if.master bus
);
    localparam int BYTES_PER_LINE = IMAGE_WIDTH / 8;
    localparam int IDX_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_LINE - 1);

    if (IMAGE_WIDTH % 8 != 0 || IMAGE_WIDTH < 8 || IMAGE_HEIGHT < 1) begin : g_bad_params
        $error("sobel_line_packer: IMAGE_WIDTH must be a positive multiple of 8");
    end

    typedef enum logic [1:0] {IDLE, HDR_HI, HDR_LO, DATA} rd_state_e;

    logic             vsync_q, hsync_q;
    logic [6:0]       shift;
    logic [2:0]       bit_cnt;
    logic [IDX_W-1:0] byte_idx;
    logic             drop_mode, wr_bank, rd_bank;
    logic [1:0]       full;
    logic [15:0]      line_num, drops;
    logic             drop_pulse;
    logic [15:0]      tag [2];
    logic [7:0]       mem [2][BYTES_PER_LINE];
    logic [7:0]       mem_q;

    logic             vsync_rise, abort, pixel, line_start, byte_done, line_done;
    logic             wr_en, full_set, full_clr, xfer;
    rd_state_e        state, state_next;
    logic [IDX_W-1:0] data_idx, idx_next;

    // Write side: an aborted line (frame start or early hsync fall) swallows that cycle's pixel.
    always_comb begin
        vsync_rise = bus.sobel_vsync & ~vsync_q;
        abort      = vsync_rise | (hsync_q & ~bus.sobel_hsync & ((bit_cnt != 3'd0) | (byte_idx != '0)));
        pixel      = bus.sobel_valid & ~abort;
        line_start = pixel & (bit_cnt == 3'd0) & (byte_idx == '0);
        byte_done  = pixel & (bit_cnt == 3'd7);
        line_done  = byte_done & (byte_idx == LAST_IDX);
        wr_en      = byte_done & ~drop_mode;
        full_set   = line_done & ~drop_mode;
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            bit_cnt    <= 3'd0;
            byte_idx   <= '0;
            drop_mode  <= 1'b0;
            wr_bank    <= 1'b0;
            line_num   <= 16'd0;
            drop_pulse <= 1'b0;
            drops      <= 16'd0;
        end else begin
            vsync_q    <= bus.sobel_vsync;
            hsync_q    <= bus.sobel_hsync;
            drop_pulse <= 1'b0;
            if (abort) begin
                bit_cnt   <= 3'd0;
                byte_idx  <= '0;
                drop_mode <= 1'b0;
                if (vsync_rise) line_num <= 16'd0;
            end else if (pixel) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (line_start) drop_mode <= full[wr_bank];
                if (line_done) begin
                    byte_idx <= '0;
                    line_num <= line_num + 16'd1;
                    if (drop_mode) begin
                        drop_pulse <= 1'b1;
                        if (drops != 16'hFFFF) drops <= drops + 16'd1;
                    end else begin
                        wr_bank <= ~wr_bank;
                    end
                end else if (byte_done) begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

    // Line store: the read port is always fetching the byte the next cycle will present.
    always_ff @(posedge clk) begin
        if (pixel) shift <= {shift[5:0], bus.sobel};
        if (wr_en) mem[wr_bank][byte_idx] <= {shift, bus.sobel};
        if (full_set) tag[wr_bank] <= line_num;
        mem_q <= mem[rd_bank][idx_next];
    end

    // The writer only sets an empty bank and the reader only clears a full one, so both can act at once.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            full <= 2'b00;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (full_set && wr_bank == 1'(b)) full[b] <= 1'b1;
                else if (full_clr && rd_bank == 1'(b)) full[b] <= 1'b0;
            end
        end
    end

    // Read FSM
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state    <= IDLE;
            data_idx <= '0;
            rd_bank  <= 1'b0;
        end else begin
            state    <= state_next;
            data_idx <= idx_next;
            rd_bank  <= rd_bank ^ full_clr;
        end
    end

    always_comb begin
        xfer       = (state != IDLE) & bus.pkt_ready;
        state_next = state;
        idx_next   = data_idx;
        full_clr   = 1'b0;
        case (state)
            IDLE:   if (full[rd_bank]) state_next = HDR_HI;
            HDR_HI: if (xfer) state_next = HDR_LO;
            HDR_LO: if (xfer) state_next = DATA;
            DATA: begin
                if (xfer) begin
                    if (data_idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                        full_clr   = 1'b1;
                    end else begin
                        idx_next = data_idx + IDX_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.pkt_data  = 8'h00;
        bus.pkt_valid = (state != IDLE);
        bus.pkt_sop   = (state == HDR_HI);
        bus.pkt_eop   = (state == DATA) && (data_idx == LAST_IDX);
        case (state)
            HDR_HI:  bus.pkt_data = tag[rd_bank][15:8];
            HDR_LO:  bus.pkt_data = tag[rd_bank][7:0];
            DATA:    bus.pkt_data = mem_q;
            default: bus.pkt_data = 8'h00;
        endcase
    end

    assign bus.line_drop  = drop_pulse;
    assign bus.drop_count = drops;
endmodule
